lsu_mem_access: RTL and testbench

Load/store unit in the MEM stage, directly upstream of the word-addressed data memory. It accepts one load or store per transaction from the pipeline and drives the memory's `we`/`re`/`data_addr`/`data_write` strobes. It performs byte and halfword loads with sign or zero extension, and performs byte and halfword stores as read-modify-write, because the data memory writes whole words only. It returns a one-cycle response carrying load data and the destination-register tag, and holds the pipeline stalled while busy.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_mem_access.sv | 132 +++++++++++++
 tb/tb_lsu_mem_access.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and op-decode helpers for the MEM-stage load/store unit.
// Misalignment checking is enabled by the LSU_ALIGN_CHECK_EN macro.
package lsu_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } lsu_state_e;

  // Op-class fields: store flag, unsigned-load flag, and access size in op[1:0]
  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op[1:0])
      SIZE_HALF: return off[0];
      SIZE_WORD: return off != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract with sign/zero extension, and the
// byte/halfword merge used by read-modify-write stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halfwords ignore addr[0]; when alignment checking is on it never reaches here set
  assign w_byte_sh = {i_off, 3'b000};
  assign w_half_sh = {i_off[1], 4'b0000};
  assign w_half    = i_off[1] ? i_rword[31:16] : i_rword[15:0];

  always_comb begin
    w_byte = i_rword[7:0];
    case (i_off)
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      2'd3:    w_byte = i_rword[31:24];
      default: w_byte = i_rword[7:0];
    endcase
  end

  always_comb begin
    o_load  = i_rword;
    o_merge = i_wdata;
    case (i_size)
      SIZE_BYTE: begin
        o_load  = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merge = (i_rword & ~(32'h0000_00FF << w_byte_sh)) |
                  ({24'h0, i_wdata[7:0]} << w_byte_sh);
      end
      SIZE_HALF: begin
        o_load  = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merge = (i_rword & ~(32'h0000_FFFF << w_half_sh)) |
                  ({16'h0, i_wdata[15:0]} << w_half_sh);
      end
      default: begin
        o_load  = i_rword;
        o_merge = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// MEM-stage load/store unit driving a word-only data memory; sub-word stores
// are read-modify-write. Define LSU_ALIGN_CHECK_EN to fault misaligned accesses.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        resp_exc,
  output logic        stall,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  if (DMEM_WORDS < 1) begin : g_bad_depth
    $error("lsu_mem_access: DMEM_WORDS must be at least 1");
  end

  lsu_state_e  r_state;
  logic [3:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [4:0]  r_rd;

  logic        w_legal;
  logic        w_fault;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign req_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign stall     = req_valid & ~req_ready;
  assign w_legal   = op_is_legal(req_op);

`ifdef LSU_ALIGN_CHECK_EN
  assign w_fault = w_legal & op_misaligned(req_op, req_addr[1:0]);
`else
  assign w_fault = 1'b0;
`endif

  // The lane logic sees mem_rdata only while in RD, the one cycle mem_re is high
  lsu_align u_align (
    .i_size     (r_op[1:0]),
    .i_unsigned (r_op[OP_UNSIGNED_BIT]),
    .i_off      (r_off),
    .i_rword    (mem_rdata),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_op       <= 4'h0;
      r_off      <= 2'b00;
      r_wdata    <= 32'h0;
      r_rd       <= 5'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_rd    <= 5'h0;
      resp_exc   <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_exc   <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (req_valid) begin
            r_op     <= req_op;
            r_off    <= req_addr[1:0];
            r_wdata  <= req_wdata;
            r_rd     <= req_rd;
            mem_addr <= {req_addr[31:2], 2'b00};
            if (!w_legal || w_fault) begin
              r_state    <= ST_DONE;
              resp_valid <= 1'b1;
              resp_rd    <= req_rd;
              resp_exc   <= w_fault;
            end else if (req_op == OP_SW) begin
              r_state   <= ST_WR;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              r_state <= ST_RD;
              mem_re  <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD: begin
          if (r_op[OP_STORE_BIT]) begin
            r_state   <= ST_WR;
            mem_we    <= 1'b1;
            mem_wdata <= w_merge;
          end else begin
            r_state    <= ST_DONE;
            resp_valid <= 1'b1;
            resp_rd    <= r_rd;
            resp_rdata <= w_load;
          end
        end
        ST_WR: begin
          r_state    <= ST_DONE;
          resp_valid <= 1'b1;
          resp_rd    <= r_rd;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_access.sv
// Scoreboard bench for lsu_mem_access: directed cases plus randomized traffic
// checked against a word-array reference model of the load/store semantics.
module tb_lsu_mem_access;
  import lsu_pkg::*;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        exc;
    int          edge_n;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_exc;
  logic        stall;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  wire  [31:0] mem_rdata;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  exp_t        sbq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_re = 0, exp_we = 0, act_re = 0, act_we = 0;

  lsu_mem_access #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_exc(resp_exc), .stall(stall),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Word-addressed data memory: combinational read, registered write
  assign mem_rdata = mem_re ? mem[mem_addr[9:2]] : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference semantics: operate on whole words with byte/halfword part-selects
  task automatic modelOp(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic exc, output int lat,
                         output int re, output int we);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    int          bo, ho;
    bit          legal, mis, fault;
    w     = ref_mem[addr[9:2]];
    bo    = int'(addr[1:0]);
    ho    = int'(addr[1]);
    legal = (op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA});
    mis   = ((op[1:0] == 2'b01) && addr[0]) || ((op[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`ifdef LSU_ALIGN_CHECK_EN
    fault = legal && mis;
`else
    fault = 1'b0;
`endif
    b = w[8*bo +: 8];
    h = w[16*ho +: 16];
    rdata = 32'h0;
    exc = fault;
    re = 0;
    we = 0;
    lat = 1;
    if (legal && !fault) begin
      case (op)
        4'h0: begin rdata = 32'($signed(b)); lat = 2; re = 1; end
        4'h1: begin rdata = 32'($signed(h)); lat = 2; re = 1; end
        4'h2: begin rdata = w; lat = 2; re = 1; end
        4'h4: begin rdata = {24'h0, b}; lat = 2; re = 1; end
        4'h5: begin rdata = {16'h0, h}; lat = 2; re = 1; end
        4'h8: begin w[8*bo +: 8] = wdata[7:0]; ref_mem[addr[9:2]] = w; lat = 3; re = 1; we = 1; end
        4'h9: begin w[16*ho +: 16] = wdata[15:0]; ref_mem[addr[9:2]] = w; lat = 3; re = 1; we = 1; end
        default: begin ref_mem[addr[9:2]] = wdata; lat = 2; we = 1; end
      endcase
    end
  endtask

  // Present a request, wait for acceptance, and record what the DUT must return
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] rd, input bit track);
    exp_t        e;
    logic [31:0] rdata;
    logic        exc;
    int          lat, re, we, waited;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    waited    = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: req_ready stayed 0 for op %0h", op);
      req_valid = 1'b0;
      return;
    end
    if (track) begin
      modelOp(op, addr, wdata, rdata, exc, lat, re, we);
      e.rd = rd; e.rdata = rdata; e.exc = exc; e.edge_n = cyc + 1; e.lat = lat;
      sbq.push_back(e);
      exp_re += re;
      exp_we += we;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL resp_timeout: %0d responses outstanding", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: strobe invariants every cycle, and scoreboard pops on each response
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      act_re += int'(mem_re);
      act_we += int'(mem_we);
      if (mem_re || mem_we) begin
        checkOutput("strobe_exclusive", {31'h0, mem_re & mem_we}, 32'h0);
        checkOutput("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
      end
      checkOutput("stall", {31'h0, stall}, {31'h0, req_valid & ~req_ready});
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_resp: resp_valid=1 with rd %0d, none expected", resp_rd);
        end else begin
          e = sbq.pop_front();
          checkOutput("resp_rd", {27'h0, resp_rd}, {27'h0, e.rd});
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("resp_exc", {31'h0, resp_exc}, {31'h0, e.exc});
          checkOutput("resp_latency", 32'(cyc - e.edge_n + 1), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] legal_ops [8];
    logic [3:0] bad_ops [8];
    logic [3:0] op;
    int         gap;
    legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
    bad_ops   = '{4'h3, 4'h6, 4'h7, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    rst = 1'b1;
    req_valid = 1'b0;
    req_op = 4'h0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_rd = 5'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[8'h10] = 32'h8899AABB;
    ref_mem[8'h10] = 32'h8899AABB;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("reset_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("reset_mem_re", {31'h0, mem_re}, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1;

    // Sub-word loads from 0x8899AABB
    applyStimulus(4'h0, 32'h41, 32'h0, 5'd1, 1'b1);
    applyStimulus(4'h4, 32'h41, 32'h0, 5'd2, 1'b1);
    applyStimulus(4'h5, 32'h42, 32'h0, 5'd3, 1'b1);
    applyStimulus(4'h1, 32'h42, 32'h0, 5'd4, 1'b1);
    waitIdle();

    // Byte RMW into 0x11223344, then read back
    applyStimulus(4'hA, 32'h40, 32'h11223344, 5'd5, 1'b1);
    applyStimulus(4'h8, 32'h43, 32'h0000005C, 5'd6, 1'b1);
    applyStimulus(4'h2, 32'h40, 32'h0, 5'd7, 1'b1);
    waitIdle();
    checkOutput("sb_merge_word", mem[8'h10], 32'h5C223344);

    // Back-to-back SW then LW, misaligned LW, illegal op
    applyStimulus(4'hA, 32'h80, 32'hDEADBEEF, 5'd8, 1'b1);
    applyStimulus(4'h2, 32'h80, 32'h0, 5'd9, 1'b1);
    applyStimulus(4'h2, 32'h82, 32'h0, 5'd10, 1'b1);
    applyStimulus(4'h3, 32'h40, 32'hFFFFFFFF, 5'd11, 1'b1);
    waitIdle();

    // Reset during the WR cycle of an SH abandons it
    applyStimulus(4'h9, 32'h84, 32'h0000CAFE, 5'd12, 1'b0);
    exp_re += 1;
    exp_we += 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rmw_wr_cycle_we", {31'h0, mem_we}, 32'h1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_mem_we", {31'h0, mem_we}, 32'h0);
    checkOutput("rst_mid_mem_re", {31'h0, mem_re}, 32'h0);
    checkOutput("rst_mid_resp_valid", {31'h0, resp_valid}, 32'h0);
    checkOutput("rst_mid_req_ready", {31'h0, req_ready}, 32'h1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(4'h2, 32'h84, 32'h0, 5'd13, 1'b1);
    waitIdle();

    // Randomized traffic with occasional illegal ops and back-to-back issue
    for (int n = 0; n < 200; n++) begin
      op  = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 7)] : bad_ops[$urandom_range(0, 7)];
      applyStimulus(op, 32'($urandom_range(0, 1023)), $urandom, 5'($urandom_range(0, 31)), 1'b1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    waitIdle();

    checkOutput("total_mem_re_cycles", 32'(act_re), 32'(exp_re));
    checkOutput("total_mem_we_cycles", 32'(act_we), 32'(exp_we));
    for (int i = 0; i < 256; i++) begin
      checkOutput($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
